// File: rtl/interleave_pingpong_ctrl.sv
// interleave_pingpong_ctrl
// Ping-pong frame buffer applying the turbo decoder's 8-symbol block
// permutation at full stream rate. Each of the two banks tracks its own
// EMPTY/FILLING/FULL/DRAINING state. The writer fills one bank while the
// reader drains the other.
// Optional feature macro: INTERLEAVER_DEINT_EN enables per-frame deinterleave
// mode (inverse table Q). Without it, only the interleave table P is used.
module interleave_pingpong_ctrl #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk_p_i,
   input  logic             reset_p_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W-1:0]     in_data_i,
   input  logic             mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     out_data_o,
   output logic             out_last_o,
   output logic             out_mode_o,
   output logic [CNT_W-1:0] frame_cnt_o
);

   typedef enum logic [1:0] {
      B_EMPTY    = 2'd0,
      B_FILLING  = 2'd1,
      B_FULL     = 2'd2,
      B_DRAINING = 2'd3
   } bank_st_e;

   // Interleave table: output k takes input P[k]
   function automatic logic [2:0] perm_p(input logic [2:0] k);
      case (k)
         3'd0:    perm_p = 3'd0;
         3'd1:    perm_p = 3'd6;
         3'd2:    perm_p = 3'd1;
         3'd3:    perm_p = 3'd3;
         3'd4:    perm_p = 3'd4;
         3'd5:    perm_p = 3'd2;
         3'd6:    perm_p = 3'd7;
         3'd7:    perm_p = 3'd5;
         default: perm_p = 3'd0;
      endcase
   endfunction

`ifdef INTERLEAVER_DEINT_EN
   // Deinterleave table: inverse of P
   function automatic logic [2:0] perm_q(input logic [2:0] k);
      case (k)
         3'd0:    perm_q = 3'd0;
         3'd1:    perm_q = 3'd2;
         3'd2:    perm_q = 3'd5;
         3'd3:    perm_q = 3'd3;
         3'd4:    perm_q = 3'd4;
         3'd5:    perm_q = 3'd7;
         3'd6:    perm_q = 3'd1;
         3'd7:    perm_q = 3'd6;
         default: perm_q = 3'd0;
      endcase
   endfunction
`endif

   logic [W-1:0]     mem_q [2][8];
   bank_st_e         bank_st_q [2];
   logic [1:0]       full_s;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [2:0]       wr_idx_q, wr_idx_d;
   logic [2:0]       rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             wr_fire_s;
   logic             rd_fire_s;
   logic             rd_mode_s;
   logic [2:0]       rd_addr_s;

`ifdef INTERLEAVER_DEINT_EN
   logic [1:0]       mode_q;
`else
   logic             unused_mode_s;
   assign unused_mode_s = mode_i;
`endif

   // A bank is "full" from its 8th write until its 8th read
   always_comb begin
      full_s = 2'b00;
      for (int b = 0; b < 2; b++) begin
         if ((bank_st_q[b] == B_FULL) || (bank_st_q[b] == B_DRAINING)) begin
            full_s[b] = 1'b1;
         end else begin
            full_s[b] = 1'b0;
         end
      end
   end

   // Handshakes, read address through the permutation, and advance values
   always_comb begin
      wr_fire_s = in_valid_i && !full_s[wr_bank_q];
      rd_fire_s = full_s[rd_bank_q] && out_ready_i;
`ifdef INTERLEAVER_DEINT_EN
      rd_mode_s = mode_q[rd_bank_q];
      if (rd_mode_s) begin
         rd_addr_s = perm_q(rd_idx_q);
      end else begin
         rd_addr_s = perm_p(rd_idx_q);
      end
`else
      rd_mode_s = 1'b0;
      rd_addr_s = perm_p(rd_idx_q);
`endif
      wr_idx_d    = wr_idx_q + 3'd1;
      rd_idx_d    = rd_idx_q + 3'd1;
      wr_bank_d   = (wr_idx_q == 3'd7) ? ~wr_bank_q : wr_bank_q;
      rd_bank_d   = (rd_idx_q == 3'd7) ? ~rd_bank_q : rd_bank_q;
      frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Bank FSMs, storage, writer/reader pointers and the drained-frame counter
   always_ff @(posedge clk_p_i) begin
      if (reset_p_i) begin
         for (int b = 0; b < 2; b++) begin
            bank_st_q[b] <= B_EMPTY;
            for (int i = 0; i < 8; i++) begin
               mem_q[b][i] <= '0;
            end
         end
`ifdef INTERLEAVER_DEINT_EN
         mode_q      <= 2'b00;
`endif
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_idx_q    <= 3'd0;
         rd_idx_q    <= 3'd0;
         frame_cnt_q <= '0;
      end else begin
         // The writer only ever touches a non-full bank and the reader only a
         // full one, so both updates below never target the same bank.
         if (wr_fire_s) begin
            mem_q[wr_bank_q][wr_idx_q] <= in_data_i;
`ifdef INTERLEAVER_DEINT_EN
            if (wr_idx_q == 3'd0) begin
               mode_q[wr_bank_q] <= mode_i;
            end
`endif
            bank_st_q[wr_bank_q] <= (wr_idx_q == 3'd7) ? B_FULL : B_FILLING;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
         end
         if (rd_fire_s) begin
            bank_st_q[rd_bank_q] <= (rd_idx_q == 3'd7) ? B_EMPTY : B_DRAINING;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
            if (rd_idx_q == 3'd7) begin
               frame_cnt_q <= frame_cnt_d;
            end
         end
      end
   end

   assign in_ready_o  = !full_s[wr_bank_q];
   assign out_valid_o = full_s[rd_bank_q];
   assign out_data_o  = mem_q[rd_bank_q][rd_addr_s];
   assign out_last_o  = full_s[rd_bank_q] && (rd_idx_q == 3'd7);
   assign out_mode_o  = rd_mode_s;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_interleave_pingpong_ctrl.sv
// Self-checking bench for interleave_pingpong_ctrl: scenario tasks drive
// frames and push expected outputs into a scoreboard queue; a forked monitor
// pops and compares on every output handshake.
module tb_interleave_pingpong_ctrl;

   localparam int W     = 8;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         last;
      logic         mode;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_last;
   logic             out_mode;
   logic [CNT_W-1:0] frame_cnt;

   interleave_pingpong_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk_p_i     (clk),
      .reset_p_i   (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .mode_i      (mode),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_mode_o  (out_mode),
      .frame_cnt_o (frame_cnt)
   );

   // Reference tables written out independently
   int tbl_p [8] = '{0, 6, 1, 3, 4, 2, 7, 5};
   int tbl_q [8] = '{0, 2, 5, 3, 4, 7, 1, 6};

   exp_t         exp_q [$];
   logic [W-1:0] out_log [$];
   logic [W-1:0] frame_d [8];
   logic         frame_m [8];
   int           checks = 0;
   int           passes = 0;
   int           cyc = 0;
   int           out_cnt = 0;
   int           first_out_cyc = 0;
   int           last_out_cyc = 0;
   int           stalls = 0;
   int           exp_frames = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for bubble measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: compares every output handshake against the queue head
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_extra: unexpected output data=%0d last=%0b", out_data, out_last);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_last, out_mode} !== {e.d, e.last, e.mode}) begin
                  $display("FAIL sb_output: got data=%0d last=%0b mode=%0b, want data=%0d last=%0b mode=%0b",
                           out_data, out_last, out_mode, e.d, e.last, e.mode);
               end else begin
                  passes++;
               end
            end
            if (out_cnt == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_cnt++;
            out_log.push_back(out_data);
         end
      end
   endtask

   // Offer one symbol and wait (bounded) for it to be accepted
   task automatic send_sym(input logic [W-1:0] d, input logic m);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      n = 0;
      @(negedge clk);
      if (!in_ready) stalls++;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL send_timeout: in_ready=%0b, want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Push the model's expected output for frame_d/frame_m
   task automatic push_model();
      exp_t e;
      logic fm;
`ifdef INTERLEAVER_DEINT_EN
      fm = frame_m[0];
`else
      fm = 1'b0;
`endif
      for (int k = 0; k < 8; k++) begin
         e.d    = fm ? frame_d[tbl_q[k]] : frame_d[tbl_p[k]];
         e.last = (k == 7);
         e.mode = fm;
         exp_q.push_back(e);
      end
      exp_frames++;
   endtask

   task automatic send_frame();
      for (int i = 0; i < 8; i++) send_sym(frame_d[i], frame_m[i]);
   endtask

   // Wait (bounded) for the scoreboard to empty plus the last handshake edge
   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) $display("FAIL drain_timeout: %0d outputs pending, want 0", exp_q.size());
      else passes++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string name);
      checks++;
      if (frame_cnt !== exp_frames[CNT_W-1:0]) $display("FAIL %s: frame_cnt=%0d, want %0d", name, frame_cnt, exp_frames);
      else passes++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_frames = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1)  $display("FAIL rst_in_ready: got %0b, want 1", in_ready);   else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b, want 0", out_valid); else passes++;
      checks++; if (out_last !== 1'b0)  $display("FAIL rst_out_last: got %0b, want 0", out_last);   else passes++;
      checks++; if (out_mode !== 1'b0)  $display("FAIL rst_out_mode: got %0b, want 0", out_mode);   else passes++;
      check_cnt("rst_frame_cnt");
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = W'(i);
         frame_m[i] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         send_sym(frame_d[i], frame_m[i]);
         if (i == 6) begin
            checks++;
            if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %0b, want 0", out_valid); else passes++;
         end
      end
      push_model();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd0) $display("FAIL single_latency: valid=%0b data=%0d, want 1/0", out_valid, out_data);
      else passes++;
      wait_drain();
      check_cnt("single_frame_cnt");
   endtask

   task automatic test_round_trip();
`ifdef INTERLEAVER_DEINT_EN
      exp_t e;
      logic [W-1:0] orig [8];
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = W'(8'd40 + 8'(i * 3));
         frame_m[i] = 1'b1;
         orig[i]    = frame_d[i];
      end
      out_log.delete();
      send_frame();
      push_model();
      wait_drain();
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = out_log[i];
         frame_m[i] = 1'b0;
      end
      send_frame();
      for (int k = 0; k < 8; k++) begin
         e.d = orig[k]; e.last = (k == 7); e.mode = 1'b0;
         exp_q.push_back(e);
      end
      exp_frames++;
      wait_drain();
      check_cnt("roundtrip_frame_cnt");
`endif
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      out_cnt   = 0;
      stalls    = 0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) begin
            frame_d[i] = W'(f * 8 + i);
            frame_m[i] = 1'b0;
         end
         send_frame();
         push_model();
      end
      wait_drain();
      checks++; if (stalls != 0)  $display("FAIL stream_in_ready: %0d stalls, want 0", stalls); else passes++;
      checks++; if (out_cnt != 32) $display("FAIL stream_count: got %0d outputs, want 32", out_cnt); else passes++;
      checks++;
      if (last_out_cyc - first_out_cyc != 31) $display("FAIL stream_bubbles: span %0d cycles, want 31", last_out_cyc - first_out_cyc);
      else passes++;
      check_cnt("stream_frame_cnt");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            frame_d[i] = W'(100 + f * 8 + i);
            frame_m[i] = 1'b0;
         end
         send_frame();
         push_model();
      end
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%0b, want 0", in_ready); else passes++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_data !== exp_q[0].d || out_last !== exp_q[0].last || out_mode !== exp_q[0].mode)
            $display("FAIL bp_hold: data=%0d last=%0b, want %0d/%0b", out_data, out_last, exp_q[0].d, exp_q[0].last);
         else passes++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_one_read: in_ready=%0b, want 0", in_ready); else passes++;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (in_ready !== (i == 7)) $display("FAIL bp_release: read %0d in_ready=%0b, want %0b", i + 1, in_ready, (i == 7));
         else passes++;
      end
      wait_drain();
      check_cnt("bp_frame_cnt");
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_sym(W'(200 + i), 1'b0);
      do_reset();
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %0b, want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1)  $display("FAIL midrst_ready: got %0b, want 1", in_ready);   else passes++;
      out_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = W'(60 + i);
         frame_m[i] = 1'b0;
      end
      send_frame();
      push_model();
      wait_drain();
      repeat (4) @(posedge clk);
      #1;
      checks++; if (out_cnt != 8) $display("FAIL midrst_count: got %0d outputs, want 8", out_cnt); else passes++;
      check_cnt("midrst_frame_cnt");
   endtask

   task automatic test_mode_glitch();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = W'(8'hA0 + 8'(i));
         frame_m[i] = (i >= 3);
      end
      send_frame();
      push_model();
      wait_drain();
      check_cnt("glitch_frame_cnt");
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      mode      = 1'b0;
      out_ready = 1'b0;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_single();
      test_round_trip();
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      test_mode_glitch();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
